uart_tx_sched: RTL and testbench

//  Transmit scheduler between the Tx FIFO and the UART Tx engine. Pops one character
//  at a time from a first-word-fall-through Tx FIFO and launches it with a one-cycle

---
 rtl/uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_uart_tx_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: pops characters from a FWFT Tx FIFO, launches the Tx engine, and inserts an inter-character gap.
// Optional clear-to-send gating is enabled with macro UART_TX_SCHED_CTS_EN.
module uart_tx_sched #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned GAP_W          = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_W      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [GAP_W-1:0]  gap_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_pop_o,
  input  logic              tx_busy_i,
  input  logic              tx_done_i,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              active_o,
  output logic              timeout_o,
  input  logic              timeout_clr_i,
`ifdef UART_TX_SCHED_CTS_EN
  input  logic              cts_ni,
`endif
  output logic [CNT_W-1:0]  char_cnt_o
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                cts_ok;
  logic                launch;

`ifdef UART_TX_SCHED_CTS_EN
  assign cts_ok = ~cts_ni;
`else
  assign cts_ok = 1'b1;
`endif

  // Reset gates launch so no pop escapes while rst_ni is held low
  assign launch = rst_ni & (state_q == ST_IDLE) & en_i & ~fifo_empty_i & ~tx_busy_i & cts_ok;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      gap_q     <= '0;
      wd_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      gap_q     <= gap_d;
      wd_q      <= wd_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; a watchdog set overrides a same-cycle clear
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    gap_d     = gap_q;
    wd_d      = wd_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q & ~timeout_clr_i;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          data_d  = fifo_data_i;
          state_d = ST_START;
        end
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        if (tx_done_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (gap_i == '0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d   = gap_i;
            state_d = ST_GAP;
          end
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_pop_o = launch;
  assign tx_start_o = (state_q == ST_START);
  assign active_o   = (state_q != ST_IDLE);
  assign tx_data_o  = data_q;
  assign timeout_o  = timeout_q;
  assign char_cnt_o = cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: FIFO/engine models, data scoreboard, table-driven spacing vectors.
module tb_uart_tx_sched;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TO_W   = 8;
  localparam int unsigned TO_CYC = 16;

  logic              clk;
  logic              rst_ni;
  logic              en_i;
  logic [GAP_W-1:0]  gap_i;
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_data_i;
  logic              fifo_pop_o;
  logic              tx_busy_i;
  logic              tx_done_i;
  logic              tx_start_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              active_o;
  logic              timeout_o;
  logic              timeout_clr_i;
  logic              cts_ni;
  logic [CNT_W-1:0]  char_cnt_o;

  uart_tx_sched #(
    .DATA_W(DATA_W), .GAP_W(GAP_W), .CNT_W(CNT_W),
    .TIMEOUT_W(TO_W), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .gap_i(gap_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
    .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i), .tx_start_o(tx_start_o),
    .tx_data_o(tx_data_o), .active_o(active_o), .timeout_o(timeout_o),
    .timeout_clr_i(timeout_clr_i),
`ifdef UART_TX_SCHED_CTS_EN
    .cts_ni(cts_ni),
`endif
    .char_cnt_o(char_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation exceeded time bound");
    $fatal(1);
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_pops = 0, n_starts = 0, n_dones = 0;
  int last_pop = 0, last_start = 0, prev_start = 0, last_done = 0;
  int eng_cnt = 0, eng_delay = 3;
  bit eng_never = 0, force_busy = 0;
  logic s_pop, s_start, s_active, s_timeout;
  logic [DATA_W-1:0] s_data;
  logic [CNT_W-1:0]  s_cnt;
  logic [CNT_W-1:0]  cnt_exp = '0;
  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] sb[$];

  typedef struct {
    int unsigned       gap;
    int                delay;
    logic [DATA_W-1:0] d0, d1, d2;
    int                exp_sp;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] b);
    fq.push_back(b);
    fifo_empty_i = 1'b0;
    fifo_data_i  = fq[0];
  endtask

  // One clock: sample at negedge, then update FIFO/engine models just after posedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_pop = fifo_pop_o; s_start = tx_start_o; s_active = active_o;
    s_timeout = timeout_o; s_data = tx_data_o; s_cnt = char_cnt_o;
    if (s_pop) begin
      n_pops++; last_pop = cyc;
      if (fq.size() == 0) chk("pop_on_empty", 32'd1, 32'd0);
      else sb.push_back(fq[0]);
    end
    if (s_start) begin
      n_starts++; prev_start = last_start; last_start = cyc;
      if (sb.size() == 0) chk("start_without_pop", 32'd1, 32'd0);
      else chk("tx_data", 32'(s_data), 32'(sb.pop_front()));
      if (!eng_never) eng_cnt = eng_delay;
    end
    @(posedge clk);
    #1;
    if (s_pop && fq.size() > 0) void'(fq.pop_front());
    tx_done_i = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        tx_done_i = 1'b1; n_dones++; last_done = cyc + 1;
      end
    end
    tx_busy_i    = (eng_cnt > 0) || force_busy;
    fifo_empty_i = (fq.size() == 0);
    fifo_data_i  = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int k = 0;
    while (n_starts < target && k < budget) begin tick(); k++; end
    if (n_starts < target) chk(name, 32'(n_starts), 32'(target));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!(s_active === 1'b0 && fq.size() == 0 && eng_cnt == 0 && sb.size() == 0) && k < budget) begin
      tick(); k++;
    end
    if (k >= budget) chk(name, 32'(s_active), 32'd0);
  endtask

  initial begin
    int base, fs, d, w, n, k;
    rst_ni = 1'b0; en_i = 1'b0; gap_i = '0; fifo_empty_i = 1'b1; fifo_data_i = '0;
    tx_busy_i = 1'b0; tx_done_i = 1'b0; timeout_clr_i = 1'b0; cts_ni = 1'b0;

    vecs[0] = '{0, 10, 8'h01, 8'h02, 8'h03, 12};
    vecs[1] = '{5, 4, 8'h10, 8'h20, 8'h30, 11};
    vecs[2] = '{1, 1, 8'hFF, 8'h00, 8'h7E, 4};
    vecs[3] = '{3, 2, 8'h3C, 8'hC3, 8'h81, 7};
    vecs[4] = '{0, 1, 8'h55, 8'hAA, 8'h0F, 3};

    // Reset state
    repeat (3) tick();
    chk("rst_pop", 32'(s_pop), 32'd0);
    chk("rst_start", 32'(s_start), 32'd0);
    chk("rst_data", 32'(s_data), 32'd0);
    chk("rst_active", 32'(s_active), 32'd0);
    chk("rst_timeout", 32'(s_timeout), 32'd0);
    chk("rst_cnt", 32'(s_cnt), 32'd0);
    rst_ni = 1'b1;

    // Single character, busy blocks launch first
    en_i = 1'b1; gap_i = '0; eng_delay = 3; force_busy = 1; tx_busy_i = 1'b1;
    push(8'hA5);
    repeat (3) tick();
    chk("busy_blocks_pop", 32'(n_pops), 32'd0);
    force_busy = 0; tx_busy_i = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!s_pop && k < 10);
    chk("first_pop", 32'(s_pop), 32'd1);
    tick();
    chk("pop_one_cycle", 32'(s_pop), 32'd0);
    chk("start_next_cycle", 32'(s_start), 32'd1);
    chk("start_data_a5", 32'(s_data), 32'hA5);
    wait_idle(30, "idle_after_a5");
    cnt_exp = cnt_exp + 1'b1;
    chk("cnt_after_a5", 32'(s_cnt), 32'(cnt_exp));
    chk("active_after_a5", 32'(s_active), 32'd0);

    // Table-driven spacing vectors, three characters each
    for (int i = 0; i < 5; i++) begin
      gap_i = GAP_W'(vecs[i].gap); eng_delay = vecs[i].delay;
      base = n_starts;
      push(vecs[i].d0); push(vecs[i].d1); push(vecs[i].d2);
      wait_starts(base + 1, 40, "vec_first_start");
      fs = last_start;
      wait_starts(base + 3, 100, "vec_all_starts");
      chk($sformatf("vec%0d_spacing", i), 32'(last_start - prev_start), 32'(vecs[i].exp_sp));
      chk($sformatf("vec%0d_span", i), 32'(last_start - fs), 32'(2 * vecs[i].exp_sp));
      wait_idle(60, "vec_idle");
      cnt_exp = cnt_exp + CNT_W'(3);
      chk($sformatf("vec%0d_cnt", i), 32'(s_cnt), 32'(cnt_exp));
    end

    // Gap sampled at done; mid-gap change ignored
    gap_i = 8'd5; eng_delay = 3;
    base = n_starts; n = n_dones;
    push(8'hC1); push(8'hC2);
    wait_starts(base + 1, 40, "gap_first_start");
    k = 0;
    while (n_dones == n && k < 20) begin tick(); k++; end
    tick();
    d = last_done;
    gap_i = 8'd1;
    wait_starts(base + 2, 40, "gap_second_start");
    chk("gap_pop_after_done", 32'(last_pop - d), 32'd6);
    chk("gap_start_spacing", 32'(last_start - prev_start), 32'd10);
    wait_idle(40, "gap_idle");
    cnt_exp = cnt_exp + CNT_W'(2);
    chk("gap_cnt", 32'(s_cnt), 32'(cnt_exp));
    gap_i = '0;

    // Watchdog timeout
    eng_never = 1;
    base = n_starts;
    push(8'h5A);
    wait_starts(base + 1, 40, "to_start");
    w = last_start + 1;
    k = 0;
    while (!s_timeout && k < 40) begin tick(); k++; end
    chk("timeout_latency", 32'(cyc - w), 32'd16);
    chk("timeout_cnt_unchanged", 32'(s_cnt), 32'(cnt_exp));
    // Second timeout with a clear in the set cycle
    push(8'h6B);
    wait_starts(base + 2, 40, "to2_start");
    w = last_start + 1;
    while (cyc < w + 14) tick();
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    tick();
    chk("timeout_set_beats_clr", 32'(s_timeout), 32'd1);
    chk("timeout_returns_idle", 32'(s_active), 32'd0);
    timeout_clr_i = 1'b1;
    tick();
    timeout_clr_i = 1'b0;
    tick();
    chk("timeout_cleared", 32'(s_timeout), 32'd0);
    eng_never = 0;

    // en_i dropped mid-character: current completes, no further pop
    eng_delay = 5;
    base = n_starts; n = n_pops;
    push(8'h11); push(8'h22); push(8'h33);
    wait_starts(base + 1, 40, "en_start");
    en_i = 1'b0;
    repeat (20) tick();
    chk("en_drop_pops", 32'(n_pops - n), 32'd1);
    chk("en_drop_fifo_left", 32'(fq.size()), 32'd2);
    cnt_exp = cnt_exp + 1'b1;
    chk("en_drop_cnt", 32'(s_cnt), 32'(cnt_exp));
    chk("en_drop_idle", 32'(s_active), 32'd0);

    // Reset during WAIT_DONE
    en_i = 1'b1;
    wait_starts(base + 2, 40, "rst_mid_start");
    tick();
    rst_ni = 1'b0;
    tick();
    tick();
    chk("rstmid_pop", 32'(s_pop), 32'd0);
    chk("rstmid_start", 32'(s_start), 32'd0);
    chk("rstmid_data", 32'(s_data), 32'd0);
    chk("rstmid_active", 32'(s_active), 32'd0);
    chk("rstmid_cnt", 32'(s_cnt), 32'd0);
    chk("rstmid_fifo", 32'(fq.size()), 32'd1);
    rst_ni = 1'b1; eng_cnt = 0; tx_done_i = 1'b0; tx_busy_i = 1'b0; sb.delete();
    cnt_exp = '0;
    wait_idle(40, "post_rst_idle");
    cnt_exp = cnt_exp + 1'b1;
    chk("post_rst_cnt", 32'(s_cnt), 32'(cnt_exp));

`ifdef UART_TX_SCHED_CTS_EN
    // Clear-to-send gating
    n = n_pops;
    cts_ni = 1'b1;
    push(8'h77);
    repeat (50) tick();
    chk("cts_blocks", 32'(n_pops - n), 32'd0);
    cts_ni = 1'b0;
    tick();
    chk("cts_pop_same_cycle", 32'(s_pop), 32'd1);
    wait_idle(40, "cts_idle");
    cnt_exp = cnt_exp + 1'b1;
    chk("cts_cnt", 32'(s_cnt), 32'(cnt_exp));
`endif

    // Counter wrap at 2**CNT_W
    eng_delay = 1; gap_i = '0;
    n = (1 << CNT_W) - int'(cnt_exp);
    base = n_starts;
    for (int i = 0; i < n; i++) push(DATA_W'(i + 8'h40));
    wait_starts(base + n, 20 * n, "wrap_starts");
    wait_idle(40, "wrap_idle");
    chk("cnt_wrap_zero", 32'(s_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
